// File: rtl/deser_pkg.sv
// Shared constants and state encoding for the serial-to-parallel deserializer.
// DATA_W is the assembled word width, CNT_W the width of the held-bit counter,
// MIN_LEN the shortest partial word kept when DESER_MIN_LEN_EN is defined.
package deser_pkg;

    localparam int DATA_W  = 16;
    localparam int CNT_W   = 5;
    localparam int MIN_LEN = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer: collects MSB-first bits while data_val_i is
// high and emits left-aligned words of up to DATA_W bits with a valid-bit count.
// Full words are emitted as soon as the last bit arrives; a burst that ends
// early flushes its partial word.
// Optional build macro DESER_MIN_LEN_EN: when defined, partial words shorter
// than MIN_LEN bits are dropped without a pulse.
//
//   state   | meaning
//   --------+-------------------------------------------
//   IDLE    | no bits held, count 0
//   COLLECT | 1..DATA_W-1 bits held in the word register
module deserializer
    import deser_pkg::*;
#(
    parameter int DATA_W = deser_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [CNT_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
    output logic              busy_o
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  word;
    logic               keep_partial;

    // Decide whether a partial word of the current length is worth emitting.
    always_comb begin
        keep_partial = 1'b1;
`ifdef DESER_MIN_LEN_EN
        keep_partial = (cnt >= CNT_W'(MIN_LEN));
`endif
    end

    // Word assembly, bit counting and output registers in one state machine.
    // Each bit is placed directly at its final left-aligned position, so a
    // partial flush needs no realignment and the unused low bits stay zero.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state            <= IDLE;
            cnt              <= '0;
            word             <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_val_i) begin
                        word  <= {data_i, {(DATA_W-1){1'b0}}};
                        cnt   <= CNT_W'(1);
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (data_val_i) begin
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            deser_data_o     <= {word[DATA_W-1:1], data_i};
                            deser_data_mod_o <= CNT_W'(DATA_W);
                            deser_data_val_o <= 1'b1;
                            word             <= '0;
                            cnt              <= '0;
                            state            <= IDLE;
                        end else begin
                            word <= word | (DATA_W'(data_i) << (DATA_W - 1 - int'(cnt)));
                            cnt  <= cnt + CNT_W'(1);
                        end
                    end else begin
                        if (keep_partial) begin
                            deser_data_o     <= word;
                            deser_data_mod_o <= cnt;
                            deser_data_val_o <= 1'b1;
                        end
                        word  <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    word  <= '0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A word is in progress exactly while the state register says COLLECT.
    assign busy_o = (state == COLLECT);

endmodule
